fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 a_operand  in  32  IEEE-754 single dividend.
REQ-004 b_operand  in  32  IEEE-754 single divisor.
REQ-005 valid_in  in  1  request strobe; accepted only when ready=1.
REQ-006 ready  out  1  high only in IDLE.
REQ-007 result  out  32  registered quotient, held until the next completion.
REQ-008 valid_out  out  1  one-cycle completion pulse.
REQ-009 Exception, Overflow, Underflow, DivByZero  out  1 each  registered status, updated with valid_out.

Function
REQ-010 SHALL accept an operation on an edge with valid_in=1 and ready=1; operands and sign (a[31]^b[31]) are latched then.
REQ-011 SHALL ignore valid_in while ready=0; no queueing.
REQ-012 FSM SHALL be IDLE -> CALC (exactly 26 cycles) -> ROUND (1 cycle) -> IDLE; valid_out is asserted in the first IDLE cycle after ROUND.
REQ-013 Latency SHALL be fixed: valid_out high exactly 28 edges after the accept edge, for all inputs including special cases.
REQ-014 An operand with exponent 0 SHALL be treated as zero (denormals flushed); otherwise the hidden bit is 1.
REQ-015 Either exponent = 255 SHALL give Exception=1, result=0x00000000, other flags 0.
REQ-016 Divisor zero with no Exception SHALL give DivByZero=1, result={sign,8'hFF,23'd0}.
REQ-017 Dividend zero with nonzero divisor SHALL give result={sign,31'd0}, all flags 0.
REQ-018 CALC SHALL use restoring division: rem starts at the dividend mantissa; each cycle, if rem>=mb, shift in quotient bit 1 and set rem-=mb, else shift in 0; then rem<<=1. This yields q[25:0].
REQ-019 If q[25]=1: mantissa=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), exponent=ea-eb+127. Otherwise: mantissa=q[23:1], guard=q[0], sticky=(rem!=0), exponent=ea-eb+126.
REQ-020 Exponent arithmetic SHALL be 10-bit signed.
REQ-021 Default rounding SHALL add (guard & sticky) to the mantissa; a carry out of bit 22 zeroes the mantissa and increments the exponent.
REQ-022 Final exponent >=255 SHALL set Overflow=1 and result={sign,8'hFF,23'd0}.
REQ-023 Final exponent <=0 SHALL set Underflow=1 and result={sign,31'd0}.
REQ-024 valid_out SHALL never be asserted in two consecutive cycles.

Reset
REQ-025 With rst_n=0 at an edge: state=IDLE, result=0, all flags=0, valid_out=0, ready=1 on the following cycle.
REQ-026 Reset during CALC or ROUND SHALL abort the operation; no valid_out is produced for it.

Configuration
REQ-027 Macro FP_DIV_RNE_EN defined: round up when guard & (sticky | mantissa[0]) (round-to-nearest-even).
REQ-028 FP_DIV_RNE_EN undefined: REQ-021 rounding. Latency and interface SHALL be identical in both builds.

Structure
REQ-029 Shared package fp32_pkg SHALL hold EXP_BIAS=127, EXP_MAX=255, MANT_W=23, QUOT_W=26 and the FSM state enum.
REQ-030 Sub-module fp_div_mant_core SHALL hold the iterative mantissa divider (rem, q, iteration counter, start/done). The top level holds the handshake, special-case decode, rounding and packing.

Verification
REQ-031 0x40C00000 / 0x40000000 -> result 0x40400000, flags 0, valid_out 28 edges after accept.
REQ-032 0x3F800000 / 0x40400000 -> 0x3EAAAAAB in both builds; 0xBF800000 / 0x40400000 -> 0xBEAAAAAB.
REQ-033 0x3F800000 / 0x80000000 -> 0xFF800000, DivByZero=1. 0x7F800000 / 0x3F800000 -> 0x00000000, Exception=1.
REQ-034 0x7F000000 / 0x00800000 -> 0x7F800000, Overflow=1. 0x00800000 / 0x7F000000 -> 0x00000000, Underflow=1.
REQ-035 A second valid_in 5 cycles after accept -> ignored: exactly one valid_out, whose result belongs to the first operands.
REQ-036 rst_n=0 at cycle 10 of CALC -> no valid_out; ready=1 next cycle; a new request completes normally.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared constants and FSM state type for the single-precision divider.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 23;
  localparam int QUOT_W   = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ROUND = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fp_div_mant_core.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, QUOT_W
// cycles per operation. A start pulse loads the operands; done_o is high
// during the cycle in which the last quotient bit is produced, after which
// q_o and rem_o hold the final values until the next start.
module fp_div_mant_core
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [MANT_W:0]   ma_i,
  input  logic [MANT_W:0]   mb_i,
  output logic              done_o,
  output logic [QUOT_W-1:0] q_o,
  output logic [MANT_W+1:0] rem_o
);

  localparam logic [4:0] CNT_LAST = 5'(QUOT_W - 1);

  logic [MANT_W+1:0] rem_q, rem_d, rem_sub;
  logic [MANT_W+1:0] mb_q;
  logic [QUOT_W-1:0] q_q, q_d;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic              ge;

  // One restoring step: compare, conditionally subtract, shift the remainder.
  // After the subtract the remainder is below mb, so it fits in MANT_W+1 bits
  // before the shift.
  always_comb begin
    ge      = (rem_q >= mb_q);
    rem_sub = ge ? (rem_q - mb_q) : rem_q;
    rem_d   = {rem_sub[MANT_W:0], 1'b0};
    q_d     = {q_q[QUOT_W-2:0], ge};
  end

  // Load on start, iterate while busy, stop after the last quotient bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      mb_q   <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= {1'b0, ma_i};
      mb_q   <= {1'b0, mb_i};
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == CNT_LAST) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign q_o    = q_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider with fixed 28-cycle latency.
// Handshake: an operation is accepted on a rising edge where valid_in=1 and
// ready=1 (ready is high only in IDLE); valid_in while busy is dropped, not
// queued. valid_out is a one-cycle pulse; result and flags are held until the
// next completion.
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is rounded up only when guard and sticky are both set.
module fp_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        valid_in,
  output logic        ready,
  output logic [31:0] result,
  output logic        valid_out,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        DivByZero,
  output logic [1:0]  dbg_state
);

  fsm_state_e state_q, state_d;

  logic              accept;
  logic              core_done;
  logic [QUOT_W-1:0] quot;
  logic [MANT_W+1:0] rem;

  // Operand decode at the accept edge (exponent 0 flushes to zero).
  logic              a_zero, b_zero, exc_in, dbz_in, azero_in;
  logic [MANT_W:0]   ma_in, mb_in;

  // Latched operation context.
  logic              sign_q, exc_q, dbz_q, azero_q;
  logic [7:0]        ea_q, eb_q;

  // Rounding and packing.
  logic signed [9:0] exp_s, exp_f;
  logic [MANT_W-1:0] mant_pre, mant_f;
  logic [MANT_W:0]   mant_sum;
  logic              guard, sticky, rnd_up;
  logic [31:0]       res_d;
  logic              exc_d, ovf_d, unf_d, dbz_d;

  // Output registers.
  logic [31:0]       result_q;
  logic              valid_out_q, exc_q_o, ovf_q, unf_q, dbz_q_o;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: CALC lasts until the core produces its last bit, ROUND is one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_in)  state_d = ST_CALC;
      ST_CALC:  if (core_done) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready     = (state_q == ST_IDLE);
    accept    = ready && valid_in;
    dbg_state = state_q;
  end

  // Special-case classification and mantissa extraction of incoming operands.
  always_comb begin
    a_zero   = (a_operand[30:23] == 8'd0);
    b_zero   = (b_operand[30:23] == 8'd0);
    exc_in   = (a_operand[30:23] == 8'hFF) || (b_operand[30:23] == 8'hFF);
    dbz_in   = b_zero && !exc_in;
    azero_in = a_zero && !b_zero && !exc_in;
    ma_in    = a_zero ? '0 : {1'b1, a_operand[22:0]};
    mb_in    = b_zero ? '0 : {1'b1, b_operand[22:0]};
  end

  // Capture sign, exponents and special-case flags on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      exc_q   <= 1'b0;
      dbz_q   <= 1'b0;
      azero_q <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
    end else if (accept) begin
      sign_q  <= a_operand[31] ^ b_operand[31];
      exc_q   <= exc_in;
      dbz_q   <= dbz_in;
      azero_q <= azero_in;
      ea_q    <= a_operand[30:23];
      eb_q    <= b_operand[30:23];
    end
  end

  // The core runs for every operation, special cases included, so latency
  // never depends on the operands.
  fp_div_mant_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .ma_i    (ma_in),
    .mb_i    (mb_in),
    .done_o  (core_done),
    .q_o     (quot),
    .rem_o   (rem)
  );

  // Normalise, round and pack the quotient; special cases take priority.
  always_comb begin
    res_d = '0;
    exc_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    dbz_d = 1'b0;
    if (quot[QUOT_W-1]) begin
      mant_pre = quot[24:2];
      guard    = quot[1];
      sticky   = quot[0] | (|rem);
      exp_s    = {2'b00, ea_q} - {2'b00, eb_q} + 10'(EXP_BIAS);
    end else begin
      mant_pre = quot[23:1];
      guard    = quot[0];
      sticky   = |rem;
      exp_s    = {2'b00, ea_q} - {2'b00, eb_q} + 10'(EXP_BIAS - 1);
    end
`ifdef FP_DIV_RNE_EN
    rnd_up = guard & (sticky | mant_pre[0]);
`else
    rnd_up = guard & sticky;
`endif
    mant_sum = {1'b0, mant_pre} + {{MANT_W{1'b0}}, rnd_up};
    if (mant_sum[MANT_W]) begin
      mant_f = '0;
      exp_f  = exp_s + 10'sd1;
    end else begin
      mant_f = mant_sum[MANT_W-1:0];
      exp_f  = exp_s;
    end
    if (exc_q) begin
      exc_d = 1'b1;
    end else if (dbz_q) begin
      dbz_d = 1'b1;
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (azero_q) begin
      res_d = {sign_q, 31'd0};
    end else if (exp_f >= $signed(10'(EXP_MAX))) begin
      ovf_d = 1'b1;
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      unf_d = 1'b1;
      res_d = {sign_q, 31'd0};
    end else begin
      res_d = {sign_q, exp_f[7:0], mant_f};
    end
  end

  // Register result and flags on leaving ROUND; valid_out pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      valid_out_q <= 1'b0;
      exc_q_o     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dbz_q_o     <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      if (state_q == ST_ROUND) begin
        valid_out_q <= 1'b1;
        result_q    <= res_d;
        exc_q_o     <= exc_d;
        ovf_q       <= ovf_d;
        unf_q       <= unf_d;
        dbz_q_o     <= dbz_d;
      end
    end
  end

  assign result    = result_q;
  assign valid_out = valid_out_q;
  assign Exception = exc_q_o;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign DivByZero = dbz_q_o;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vectors, randomized operations
// against an arithmetic reference model, busy-drop, reset abort and
// back-to-back issue. Flags are compared as {Exception,Overflow,Underflow,DivByZero}.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        valid_in = 1'b0;
  logic        ready;
  logic [31:0] result;
  logic        valid_out;
  logic        Exception, Overflow, Underflow, DivByZero;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  fp_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .valid_in  (valid_in),
    .ready     (ready),
    .result    (result),
    .valid_out (valid_out),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .DivByZero (DivByZero),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: exact integer quotient of the scaled mantissas, then the
  // normalise/round/range rules. Returns {result, exc, ovf, unf, dbz}.
  function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, e;
    logic            s, g, st, up;
    longint unsigned ma, mb, num, q, mant;
    logic [31:0]     r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return {32'h0, 4'b1000};
    if (eb == 0) return {s, 8'hFF, 23'd0, 4'b0001};
    if (ea == 0) return {s, 31'd0, 4'b0000};
    ma  = 64'h800000 | 64'(a[22:0]);
    mb  = 64'h800000 | 64'(b[22:0]);
    num = ma << 25;
    q   = num / mb;
    if (((q >> 25) & 64'd1) == 64'd1) begin
      mant = (q >> 2) & 64'h7FFFFF;
      g    = q[1];
      st   = q[0] | ((num % mb) != 0);
      e    = ea - eb + 127;
    end else begin
      mant = (q >> 1) & 64'h7FFFFF;
      g    = q[0];
      st   = ((num % mb) != 0);
      e    = ea - eb + 126;
    end
`ifdef FP_DIV_RNE_EN
    up = g & (st | mant[0]);
`else
    up = g & st;
`endif
    mant = mant + 64'(up);
    if (mant == 64'h800000) begin
      mant = 0;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0100};
    if (e <= 0)   return {s, 31'd0, 4'b0010};
    r = {s, 8'(e), mant[22:0]};
    return {r, 4'b0000};
  endfunction

  function automatic logic [31:0] rand_operand();
    int          kind;
    logic [7:0]  e;
    kind = $urandom_range(0, 19);
    if (kind == 0)      e = 8'd0;
    else if (kind == 1) e = 8'hFF;
    else if (kind <= 4) e = 8'($urandom_range(1, 254));
    else                e = 8'($urandom_range(97, 157));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Driver: issue one operation from a negedge, wait for its completion.
  // Returns at the negedge where valid_out was seen; lat counts that negedge
  // as edge N relative to the accept edge, or -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    a_operand = a;
    b_operand = b;
    valid_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    lat = 1;
    while (valid_out !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    f = {Exception, Overflow, Underflow, DivByZero};
    if (valid_out !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    total++; if ({Exception, Overflow, Underflow, DivByZero} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {Exception, Overflow, Underflow, DivByZero}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [9] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h7F800000,
                            32'h7F000000, 32'h00800000, 32'h00000000, 32'h80000000};
    logic [31:0] vb [9] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h80000000, 32'h3F800000,
                            32'h00800000, 32'h7F000000, 32'h40000000, 32'h3F800000};
    logic [31:0] vr [9] = '{32'h40400000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hFF800000, 32'h00000000,
                            32'h7F800000, 32'h00000000, 32'h00000000, 32'h80000000};
    logic [3:0]  vf [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000,
                            4'b0100, 4'b0010, 4'b0000, 4'b0000};
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], r, f, lat);
      total++; if (r !== vr[i]) begin bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, vr[i]); end
      total++; if (f !== vf[i]) begin bad++; $display("FAIL directed_flags[%0d] got=%b want=%b", i, f, vf[i]); end
      total++; if (lat != 28) begin bad++; $display("FAIL directed_latency[%0d] got=%0d want=28", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic [35:0] e;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp_q.push_back(ref_div(a, b));
      run_op(a, b, r, f, lat);
      e = exp_q.pop_front();
      total++; if ({r, f} !== e) begin
        bad++; $display("FAIL random[%0d] a=%h b=%h got=%h/%b want=%h/%b", i, a, b, r, f, e[35:4], e[3:0]); end
      total++; if (lat != 28) begin bad++; $display("FAIL random_latency[%0d] got=%0d want=28", i, lat); end
    end
  endtask

  // A request arriving while busy must be dropped without disturbing the first.
  task automatic test_ignore_busy();
    logic [31:0] a, b, got;
    logic [35:0] e;
    int          pulses, glat;
    a = 32'h40490FDB;
    b = 32'h402DF854;
    e = ref_div(a, b);
    pulses = 0; glat = -1; got = '0;
    a_operand = a; b_operand = b; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int n = 1; n <= 50; n++) begin
      if (n > 1) @(negedge clk);
      if (valid_out === 1'b1) begin pulses++; got = result; glat = n; end
      if (n >= 5 && n <= 8) begin
        a_operand = 32'h3F800000; b_operand = 32'h40400000; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
    total++; if (got !== e[35:4]) begin bad++; $display("FAIL ignore_result got=%h want=%h", got, e[35:4]); end
    total++; if (glat != 28) begin bad++; $display("FAIL ignore_latency got=%0d want=28", glat); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic [35:0] e;
    int          pulses, lat;
    a_operand = 32'h40C00000; b_operand = 32'h40000000; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h want=00000000", result); end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid_out === 1'b1) pulses++;
      @(negedge clk);
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    a = 32'hC1200000;
    b = 32'h40800000;
    e = ref_div(a, b);
    run_op(a, b, r, f, lat);
    total++; if ({r, f} !== e) begin bad++; $display("FAIL abort_next got=%h/%b want=%h/%b", r, f, e[35:4], e[3:0]); end
    total++; if (lat != 28) begin bad++; $display("FAIL abort_next_latency got=%0d want=28", lat); end
  endtask

  // Issue each operation in the first IDLE cycle after the previous completion.
  task automatic test_back_to_back();
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic [35:0] e;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      a = rand_operand();
      b = rand_operand();
      e = ref_div(a, b);
      run_op(a, b, r, f, lat);
      total++; if ({r, f} !== e) begin
        bad++; $display("FAIL b2b[%0d] got=%h/%b want=%h/%b", i, r, f, e[35:4], e[3:0]); end
      total++; if (lat != 28) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=28", i, lat); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
